// File: rtl/issueque_int_if.sv
// Dispatch, CDB snoop, flush and issue handshake bundle for the integer issue queue.
// master = dispatch/CDB/ALU side, slave = the queue itself.
interface issueque_int_if #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
);
  logic              dispatch_en;
  logic              dispatch_ready;
  logic [31:0]       dispatch_inst;
  logic [TAG_W-1:0]  dispatch_rdtag;
  logic [DATA_W-1:0] dispatch_rsdata;
  logic [TAG_W-1:0]  dispatch_rstag;
  logic              dispatch_rsvalid;
  logic [DATA_W-1:0] dispatch_rtdata;
  logic [TAG_W-1:0]  dispatch_rttag;
  logic              dispatch_rtvalid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_valid;
  logic              flush;
  logic              issue_valid;
  logic              issue_ready;
  logic [31:0]       issue_inst;
  logic [TAG_W-1:0]  issue_rdtag;
  logic [DATA_W-1:0] issue_rsdata;
  logic [DATA_W-1:0] issue_rtdata;

  modport master (
    output dispatch_en, dispatch_inst, dispatch_rdtag,
           dispatch_rsdata, dispatch_rstag, dispatch_rsvalid,
           dispatch_rtdata, dispatch_rttag, dispatch_rtvalid,
           cdb_tag, cdb_data, cdb_valid, flush, issue_ready,
    input  dispatch_ready, issue_valid, issue_inst, issue_rdtag,
           issue_rsdata, issue_rtdata
  );

  modport slave (
    input  dispatch_en, dispatch_inst, dispatch_rdtag,
           dispatch_rsdata, dispatch_rstag, dispatch_rsvalid,
           dispatch_rtdata, dispatch_rttag, dispatch_rtvalid,
           cdb_tag, cdb_data, cdb_valid, flush, issue_ready,
    output dispatch_ready, issue_valid, issue_inst, issue_rdtag,
           issue_rsdata, issue_rtdata
  );
endinterface

// File: rtl/issueque_int.sv
// Age-ordered integer issue queue: collapses on issue, wakes operands from the CDB,
// and issues the oldest ready entry, holding its choice stable under ALU backpressure.
module issueque_int #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  issueque_int_if.slave q
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [31:0]       inst_q    [DEPTH];
  logic [TAG_W-1:0]  rd_q      [DEPTH];
  logic [DATA_W-1:0] rs_data_q [DEPTH];
  logic [TAG_W-1:0]  rs_tag_q  [DEPTH];
  logic [DATA_W-1:0] rt_data_q [DEPTH];
  logic [TAG_W-1:0]  rt_tag_q  [DEPTH];
  logic [DEPTH-1:0]  rs_vld_q, rt_vld_q;
  logic [CW-1:0]     count_q;
  logic              hold_q;
  logic [IW-1:0]     hold_idx_q;

  logic [31:0]       inst_n    [DEPTH];
  logic [TAG_W-1:0]  rd_n      [DEPTH];
  logic [DATA_W-1:0] rs_data_n [DEPTH];
  logic [TAG_W-1:0]  rs_tag_n  [DEPTH];
  logic [DATA_W-1:0] rt_data_n [DEPTH];
  logic [TAG_W-1:0]  rt_tag_n  [DEPTH];
  logic [DEPTH-1:0]  rs_vld_n, rt_vld_n;

  logic [DATA_W-1:0] rs_data_s [DEPTH];
  logic [DATA_W-1:0] rt_data_s [DEPTH];
  logic [DEPTH-1:0]  rs_vld_s, rt_vld_s;
  logic [DEPTH-1:0]  ent_vld, rdy;

  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  logic              xfer, wr;
  logic [CW-1:0]     count_after, count_n;
  logic [IW-1:0]     src;
  logic              wr_rs_hit, wr_rt_hit;

  // CDB snoop applied to stored entries; readiness uses registered bits only
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i]   = i < int'(count_q);
      rdy[i]       = ent_vld[i] & rs_vld_q[i] & rt_vld_q[i];
      rs_vld_s[i]  = rs_vld_q[i];
      rs_data_s[i] = rs_data_q[i];
      rt_vld_s[i]  = rt_vld_q[i];
      rt_data_s[i] = rt_data_q[i];
      if (!rs_vld_q[i] && q.cdb_valid && q.cdb_tag == rs_tag_q[i]) begin
        rs_vld_s[i]  = 1'b1;
        rs_data_s[i] = q.cdb_data;
      end
      if (!rt_vld_q[i] && q.cdb_valid && q.cdb_tag == rt_tag_q[i]) begin
        rt_vld_s[i]  = 1'b1;
        rt_data_s[i] = q.cdb_data;
      end
    end
  end

  // A choice presented under backpressure is pinned until it transfers
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    if (hold_q) begin
      sel_found = 1'b1;
      sel_idx   = hold_idx_q;
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (rdy[i]) begin
          sel_found = 1'b1;
          sel_idx   = IW'(i);
        end
      end
    end
  end

  assign q.dispatch_ready = ~rst & (count_q < CW'(DEPTH));
  assign q.issue_valid    = sel_found & ~rst;
  assign q.issue_inst     = q.issue_valid ? inst_q[sel_idx]    : '0;
  assign q.issue_rdtag    = q.issue_valid ? rd_q[sel_idx]      : '0;
  assign q.issue_rsdata   = q.issue_valid ? rs_data_q[sel_idx] : '0;
  assign q.issue_rtdata   = q.issue_valid ? rt_data_q[sel_idx] : '0;

  assign xfer        = q.issue_valid & q.issue_ready;
  assign wr          = q.dispatch_en & q.dispatch_ready;
  assign count_after = count_q - CW'(xfer);
  assign count_n     = count_after + CW'(wr);
  assign wr_rs_hit   = ~q.dispatch_rsvalid & q.cdb_valid & (q.cdb_tag == q.dispatch_rstag);
  assign wr_rt_hit   = ~q.dispatch_rtvalid & q.cdb_valid & (q.cdb_tag == q.dispatch_rttag);

  // Collapse above the issued slot, then append the new op at the new tail
  always_comb begin
    src = '0;
    for (int i = 0; i < DEPTH; i++) begin
      src = (xfer && i >= int'(sel_idx) && i < DEPTH - 1) ? IW'(i + 1) : IW'(i);
      inst_n[i]    = inst_q[src];
      rd_n[i]      = rd_q[src];
      rs_tag_n[i]  = rs_tag_q[src];
      rt_tag_n[i]  = rt_tag_q[src];
      rs_data_n[i] = rs_data_s[src];
      rt_data_n[i] = rt_data_s[src];
      rs_vld_n[i]  = rs_vld_s[src];
      rt_vld_n[i]  = rt_vld_s[src];
      if (wr && i == int'(count_after)) begin
        inst_n[i]    = q.dispatch_inst;
        rd_n[i]      = q.dispatch_rdtag;
        rs_tag_n[i]  = q.dispatch_rstag;
        rt_tag_n[i]  = q.dispatch_rttag;
        rs_data_n[i] = wr_rs_hit ? q.cdb_data : q.dispatch_rsdata;
        rt_data_n[i] = wr_rt_hit ? q.cdb_data : q.dispatch_rtdata;
        rs_vld_n[i]  = q.dispatch_rsvalid | wr_rs_hit;
        rt_vld_n[i]  = q.dispatch_rtvalid | wr_rt_hit;
      end
      if (i >= int'(count_n)) begin
        rs_vld_n[i] = 1'b0;
        rt_vld_n[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      count_q    <= '0;
      rs_vld_q   <= '0;
      rt_vld_q   <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      count_q    <= count_n;
      rs_vld_q   <= rs_vld_n;
      rt_vld_q   <= rt_vld_n;
      hold_q     <= q.issue_valid & ~q.issue_ready;
      hold_idx_q <= sel_idx;
    end
  end

  // Payload needs no reset; validity is carried by count and the operand bits
  always_ff @(posedge clk) begin
    inst_q    <= inst_n;
    rd_q      <= rd_n;
    rs_tag_q  <= rs_tag_n;
    rt_tag_q  <= rt_tag_n;
    rs_data_q <= rs_data_n;
    rt_data_q <= rt_data_n;
  end
endmodule

// File: tb/tb_issueque_int.sv
// Bench for issueque_int: queue-of-entries reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_issueque_int;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issueque_int_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();
  issueque_int #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .q(bus)
  );

  typedef struct {
    logic [31:0]       inst;
    logic [TAG_W-1:0]  rd;
    logic [DATA_W-1:0] rsd;
    logic [TAG_W-1:0]  rst_tag;
    logic              rsv;
    logic [DATA_W-1:0] rtd;
    logic [TAG_W-1:0]  rtt;
    logic              rtv;
    int                uid;
  } ent_t;

  ent_t mq[$];
  int lock_uid = -1;
  int next_uid = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Oldest ready op, unless an op was already offered and is still waiting for the ALU
  function automatic int msel();
    if (lock_uid >= 0)
      foreach (mq[k]) if (mq[k].uid == lock_uid) return k;
    foreach (mq[k]) if (mq[k].rsv && mq[k].rtv) return k;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int s;
    bit room;
    ent_t e;
    if (rst || bus.flush) begin
      mq.delete();
      lock_uid = -1;
    end else begin
      room = mq.size() < DEPTH;
      s = msel();
      foreach (mq[k]) begin
        if (bus.cdb_valid && !mq[k].rsv && mq[k].rst_tag == bus.cdb_tag) begin
          mq[k].rsv = 1'b1; mq[k].rsd = bus.cdb_data;
        end
        if (bus.cdb_valid && !mq[k].rtv && mq[k].rtt == bus.cdb_tag) begin
          mq[k].rtv = 1'b1; mq[k].rtd = bus.cdb_data;
        end
      end
      if (s >= 0 && bus.issue_ready) begin
        mq.delete(s);
        lock_uid = -1;
      end else if (s >= 0) begin
        lock_uid = mq[s].uid;
      end
      if (bus.dispatch_en && room) begin
        e.inst = bus.dispatch_inst;  e.rd = bus.dispatch_rdtag;
        e.rst_tag = bus.dispatch_rstag; e.rtt = bus.dispatch_rttag;
        e.rsv = bus.dispatch_rsvalid; e.rsd = bus.dispatch_rsdata;
        e.rtv = bus.dispatch_rtvalid; e.rtd = bus.dispatch_rtdata;
        if (!e.rsv && bus.cdb_valid && bus.cdb_tag == e.rst_tag) begin e.rsv = 1'b1; e.rsd = bus.cdb_data; end
        if (!e.rtv && bus.cdb_valid && bus.cdb_tag == e.rtt) begin e.rtv = 1'b1; e.rtd = bus.cdb_data; end
        e.uid = next_uid++;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    int s;
    bit v;
    #2;
    s = msel();
    v = !rst && s >= 0;
    chk("dispatch_ready", 32'(bus.dispatch_ready), 32'(!rst && mq.size() < DEPTH));
    chk("issue_valid", 32'(bus.issue_valid), 32'(v));
    chk("issue_inst", bus.issue_inst, v ? mq[s].inst : 32'h0);
    chk("issue_rdtag", 32'(bus.issue_rdtag), v ? 32'(mq[s].rd) : 32'h0);
    chk("issue_rsdata", bus.issue_rsdata, v ? mq[s].rsd : 32'h0);
    chk("issue_rtdata", bus.issue_rtdata, v ? mq[s].rtd : 32'h0);
  end

  task automatic nxt();
    @(negedge clk);
    bus.dispatch_en = 1'b0;
    bus.cdb_valid   = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic disp(input logic [31:0] inst, input logic [5:0] rd,
                      input logic [31:0] rsd, input logic [5:0] rstag, input logic rsv,
                      input logic [31:0] rtd, input logic [5:0] rttag, input logic rtv);
    bus.dispatch_en = 1'b1;     bus.dispatch_inst = inst;   bus.dispatch_rdtag = rd;
    bus.dispatch_rsdata = rsd;  bus.dispatch_rstag = rstag; bus.dispatch_rsvalid = rsv;
    bus.dispatch_rtdata = rtd;  bus.dispatch_rttag = rttag; bus.dispatch_rtvalid = rtv;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1; bus.cdb_tag = tag; bus.cdb_data = data;
  endtask

  initial begin
    bus.issue_ready = 1'b0;
    bus.dispatch_en = 1'b0; bus.cdb_valid = 1'b0; bus.flush = 1'b0;
    disp(32'h0, 6'd0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0);
    bus.dispatch_en = 1'b0;
    bus.cdb_tag = '0; bus.cdb_data = '0;

    // T1 reset
    nxt(); rst = 1'b1; #3;
    chk("t1_ready_in_rst", 32'(bus.dispatch_ready), 32'h0);
    chk("t1_valid_in_rst", 32'(bus.issue_valid), 32'h0);
    nxt(); #3;
    chk("t1_ready_in_rst2", 32'(bus.dispatch_ready), 32'h0);
    nxt(); rst = 1'b0; #3;
    chk("t1_ready_after", 32'(bus.dispatch_ready), 32'h1);
    chk("t1_valid_after", 32'(bus.issue_valid), 32'h0);

    // T2 ready on arrival
    nxt(); bus.issue_ready = 1'b1;
    disp(32'h012A4020, 6'd1, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1);
    nxt(); #3;
    chk("t2_valid", 32'(bus.issue_valid), 32'h1);
    chk("t2_inst", bus.issue_inst, 32'h012A4020);
    chk("t2_rs", bus.issue_rsdata, 32'd5);
    chk("t2_rt", bus.issue_rtdata, 32'd7);
    nxt(); #3;
    chk("t2_drained", 32'(bus.issue_valid), 32'h0);

    // T3 wakeup through CDB, no bypass
    nxt(); disp(32'h3, 6'd2, 32'h0, 6'd9, 1'b0, 32'h11, 6'd0, 1'b1);
    nxt();
    nxt(); cdb(6'd9, 32'hDEAD); #3;
    chk("t3_no_bypass", 32'(bus.issue_valid), 32'h0);
    nxt(); #3;
    chk("t3_valid", 32'(bus.issue_valid), 32'h1);
    chk("t3_rs", bus.issue_rsdata, 32'hDEAD);
    nxt();

    // T4 capture on the dispatch cycle
    nxt(); disp(32'h4, 6'd3, 32'h66, 6'd0, 1'b1, 32'h0, 6'd3, 1'b0); cdb(6'd3, 32'h55);
    nxt(); #3;
    chk("t4_valid", 32'(bus.issue_valid), 32'h1);
    chk("t4_rt", bus.issue_rtdata, 32'h55);
    nxt();

    // T5 full queue, wake out of order, hold under backpressure, collapse
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt(); disp(32'h100 + i, 6'(20 + i), 32'h0, 6'(10 + i), 1'b0, 32'h200 + i, 6'd0, 1'b1);
    end
    nxt(); #3;
    chk("t5_full", 32'(bus.dispatch_ready), 32'h0);
    nxt(); cdb(6'd12, 32'hA2); disp(32'hBAD, 6'd63, 32'h1, 6'd0, 1'b1, 32'h2, 6'd0, 1'b1); #3;
    chk("t5_full2", 32'(bus.dispatch_ready), 32'h0);
    nxt(); #3;
    chk("t5_e2_rd", 32'(bus.issue_rdtag), 32'd22);
    chk("t5_e2_rs", bus.issue_rsdata, 32'hA2);
    nxt(); cdb(6'd10, 32'hA0); #3;
    chk("t5_hold1", 32'(bus.issue_rdtag), 32'd22);
    nxt(); #3;
    chk("t5_hold2", 32'(bus.issue_rdtag), 32'd22);
    bus.issue_ready = 1'b1;
    nxt(); #3;
    chk("t5_e0_rd", 32'(bus.issue_rdtag), 32'd20);
    chk("t5_e0_rs", bus.issue_rsdata, 32'hA0);
    nxt(); cdb(6'd13, 32'hA3); #3;
    chk("t5_gap", 32'(bus.issue_valid), 32'h0);
    nxt(); #3;
    chk("t5_e3_rd", 32'(bus.issue_rdtag), 32'd23);
    chk("t5_e3_rt", bus.issue_rtdata, 32'h203);

    // T6 backpressure stability, then flush beats dispatch
    nxt(); bus.flush = 1'b1; bus.issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt(); disp(32'h300 + i, 6'(30 + i), 32'h400 + i, 6'd0, 1'b1, 32'h500 + i, 6'd0, 1'b1);
    end
    nxt(); #3;
    chk("t6_first", 32'(bus.issue_rdtag), 32'd30);
    nxt(); #3;
    chk("t6_stable", bus.issue_rsdata, 32'h400);
    nxt(); bus.flush = 1'b1; disp(32'h999, 6'd40, 32'h1, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1);
    nxt(); #3;
    chk("t6_flushed", 32'(bus.issue_valid), 32'h0);
    chk("t6_ready", 32'(bus.dispatch_ready), 32'h1);

    // Randomized traffic with a narrow tag space so wakeups are frequent
    for (int c = 0; c < 3000; c++) begin
      nxt();
      rst = ($urandom_range(0, 499) == 0);
      bus.issue_ready = ($urandom_range(0, 1) == 1);
      bus.flush = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 9) < 6)
        disp($urandom, 6'($urandom_range(0, 63)),
             $urandom, 6'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
             $urandom, 6'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 1) == 1) cdb(6'($urandom_range(0, 7)), $urandom);
    end
    nxt(); rst = 1'b0;
    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
